// File: rtl/axi_pkg.sv
// Shared AXI4 encodings and FSM state types for the memory responder.
package axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [2:0] SIZE_4B = 3'b010;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         rd_state_t;

    // Only full-word FIXED and INCR bursts touch memory.
    function automatic logic burst_ok(input logic [1:0] burst, input logic [2:0] size);
        return (size == SIZE_4B) && ((burst == BURST_FIXED) || (burst == BURST_INCR));
    endfunction

    function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [1:0] burst);
        return (burst == BURST_INCR) ? addr + 32'd4 : addr;
    endfunction

endpackage

// File: rtl/axi_mem_array.sv
// Simple dual-port word memory: byte-enabled write port, registered read port
// returning old data on a same-cycle read/write of one word.
module axi_mem_array #(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [3:0]    wstrb,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (wstrb[i]) mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/axi_mem_responder.sv
// AXI4 slave backed by a byte-writable word memory; independent write and read
// FSMs, one outstanding transaction per direction.
module axi_mem_responder
    import axi_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic        s_axi_awvalid,
    output logic        s_axi_awready,
    input  logic [31:0] s_axi_awaddr,
    input  logic [7:0]  s_axi_awlen,
    input  logic [2:0]  s_axi_awsize,
    input  logic [1:0]  s_axi_awburst,
    input  logic        s_axi_awlock,
    input  logic [3:0]  s_axi_awcache,
    input  logic [2:0]  s_axi_awprot,
    input  logic [3:0]  s_axi_awqos,
    input  logic        s_axi_wvalid,
    output logic        s_axi_wready,
    input  logic [31:0] s_axi_wdata,
    input  logic [3:0]  s_axi_wstrb,
    input  logic        s_axi_wlast,
    output logic        s_axi_bvalid,
    input  logic        s_axi_bready,
    output logic [1:0]  s_axi_bresp,
    input  logic        s_axi_arvalid,
    output logic        s_axi_arready,
    input  logic [31:0] s_axi_araddr,
    input  logic [7:0]  s_axi_arlen,
    input  logic [2:0]  s_axi_arsize,
    input  logic [1:0]  s_axi_arburst,
    input  logic        s_axi_arlock,
    input  logic [3:0]  s_axi_arcache,
    input  logic [2:0]  s_axi_arprot,
    input  logic [3:0]  s_axi_arqos,
    output logic        s_axi_rvalid,
    input  logic        s_axi_rready,
    output logic [31:0] s_axi_rdata,
    output logic [1:0]  s_axi_rresp,
    output logic        s_axi_rlast
);

    localparam int unsigned AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    // BASE_ADDR is aligned to the memory size, so the offset's high bits decide range.
    function automatic logic in_range(input logic [31:0] addr);
        return ((addr - BASE_ADDR) >> (AW + 2)) == 32'd0;
    endfunction

    function automatic logic [AW-1:0] word_idx(input logic [31:0] addr);
        return AW'((addr - BASE_ADDR) >> 2);
    endfunction

    logic unused_sigs;
    assign unused_sigs = ^{s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_awqos,
                           s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arqos};

    wr_state_t   wr_state, wr_next;
    logic [31:0] wr_addr;
    logic [7:0]  wr_len, wr_beat;
    logic [1:0]  wr_burst;
    logic        wr_fmt_ok, wr_dec_err, wr_slv_err;
    logic        aw_hs, w_hs, b_hs, w_last_beat;

    rd_state_t   rd_state, rd_next;
    logic [31:0] rd_addr;
    logic [7:0]  rd_len, rd_beat;
    logic [1:0]  rd_burst;
    logic        rd_fmt_ok, rd_ok, rlast_q;
    logic [1:0]  rresp_q;
    logic        ar_hs, r_hs, r_last_beat;

    logic          mem_we, mem_re, ld_fmt;
    logic [31:0]   ld_addr, mem_rdata;
    logic [AW-1:0] mem_raddr;

    assign aw_hs       = s_axi_awvalid & s_axi_awready;
    assign w_hs        = s_axi_wvalid & s_axi_wready;
    assign b_hs        = s_axi_bvalid & s_axi_bready;
    assign w_last_beat = (wr_beat == wr_len);
    assign ar_hs       = s_axi_arvalid & s_axi_arready;
    assign r_hs        = s_axi_rvalid & s_axi_rready;
    assign r_last_beat = (rd_beat == rd_len);

    always_ff @(posedge aclk) begin
        if (areset) wr_state <= W_IDLE;
        else        wr_state <= wr_next;
    end

    always_comb begin
        wr_next = wr_state;
        case (wr_state)
            W_IDLE:  if (aw_hs)               wr_next = W_DATA;
            W_DATA:  if (w_hs && w_last_beat) wr_next = W_RESP;
            W_RESP:  if (b_hs)                wr_next = W_IDLE;
            default:                          wr_next = W_IDLE;
        endcase
    end

    always_comb begin
        s_axi_awready = !areset && (wr_state == W_IDLE);
        s_axi_wready  = !areset && (wr_state == W_DATA);
        s_axi_bvalid  = !areset && (wr_state == W_RESP);
        s_axi_bresp   = wr_dec_err ? RESP_DECERR : (wr_slv_err ? RESP_SLVERR : RESP_OKAY);
    end

    // Beat count follows awlen; wlast is only checked against it.
    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_beat    <= '0;
            wr_dec_err <= 1'b0;
            wr_slv_err <= 1'b0;
        end else if (aw_hs) begin
            wr_addr    <= s_axi_awaddr;
            wr_len     <= s_axi_awlen;
            wr_burst   <= s_axi_awburst;
            wr_fmt_ok  <= burst_ok(s_axi_awburst, s_axi_awsize);
            wr_beat    <= '0;
            wr_dec_err <= 1'b0;
            wr_slv_err <= !burst_ok(s_axi_awburst, s_axi_awsize);
        end else if (w_hs) begin
            wr_addr <= next_addr(wr_addr, wr_burst);
            wr_beat <= wr_beat + 8'd1;
            if (!in_range(wr_addr))          wr_dec_err <= 1'b1;
            if (s_axi_wlast != w_last_beat)  wr_slv_err <= 1'b1;
        end
    end

    assign mem_we = w_hs && wr_fmt_ok && in_range(wr_addr);

    always_ff @(posedge aclk) begin
        if (areset) rd_state <= R_IDLE;
        else        rd_state <= rd_next;
    end

    always_comb begin
        rd_next = rd_state;
        case (rd_state)
            R_IDLE:  if (ar_hs)               rd_next = R_DATA;
            R_DATA:  if (r_hs && r_last_beat) rd_next = R_IDLE;
            default:                          rd_next = R_IDLE;
        endcase
    end

    always_comb begin
        s_axi_arready = !areset && (rd_state == R_IDLE);
        s_axi_rvalid  = !areset && (rd_state == R_DATA);
        s_axi_rdata   = rd_ok ? mem_rdata : '0;
        s_axi_rresp   = rresp_q;
        s_axi_rlast   = rlast_q;
    end

    // The word for the next beat is fetched on the accepting edge so beats run back to back.
    always_comb begin
        ld_addr   = (rd_state == R_IDLE) ? s_axi_araddr : next_addr(rd_addr, rd_burst);
        ld_fmt    = (rd_state == R_IDLE) ? burst_ok(s_axi_arburst, s_axi_arsize) : rd_fmt_ok;
        mem_re    = (ar_hs || (r_hs && !r_last_beat)) && ld_fmt && in_range(ld_addr);
        mem_raddr = word_idx(ld_addr);
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            rd_beat <= '0;
            rd_ok   <= 1'b0;
            rresp_q <= RESP_OKAY;
            rlast_q <= 1'b0;
        end else if (ar_hs) begin
            rd_addr   <= s_axi_araddr;
            rd_len    <= s_axi_arlen;
            rd_burst  <= s_axi_arburst;
            rd_fmt_ok <= ld_fmt;
            rd_beat   <= '0;
            rd_ok     <= mem_re;
            rresp_q   <= !ld_fmt ? RESP_SLVERR : (in_range(ld_addr) ? RESP_OKAY : RESP_DECERR);
            rlast_q   <= (s_axi_arlen == 8'd0);
        end else if (r_hs) begin
            if (r_last_beat) begin
                rd_ok   <= 1'b0;
                rresp_q <= RESP_OKAY;
                rlast_q <= 1'b0;
            end else begin
                rd_addr <= ld_addr;
                rd_beat <= rd_beat + 8'd1;
                rd_ok   <= mem_re;
                rresp_q <= !ld_fmt ? RESP_SLVERR : (in_range(ld_addr) ? RESP_OKAY : RESP_DECERR);
                rlast_q <= ((rd_beat + 8'd1) == rd_len);
            end
        end
    end

    axi_mem_array #(
        .DEPTH(MEM_WORDS),
        .AW   (AW)
    ) u_mem (
        .clk  (aclk),
        .we   (mem_we),
        .waddr(word_idx(wr_addr)),
        .wdata(s_axi_wdata),
        .wstrb(s_axi_wstrb),
        .re   (mem_re),
        .raddr(mem_raddr),
        .rdata(mem_rdata)
    );

endmodule

// File: tb/tb_axi_mem_responder.sv
// Scoreboard bench for axi_mem_responder: directed and random bursts against a
// word-array reference model, responses checked by an independent monitor.
module tb_axi_mem_responder;

    localparam int unsigned MEM_WORDS = 64;
    localparam logic [31:0] BASE_ADDR = 32'h0000_0000;

    logic        aclk = 1'b0;
    logic        areset;
    logic        s_axi_awvalid, s_axi_awready;
    logic [31:0] s_axi_awaddr;
    logic [7:0]  s_axi_awlen;
    logic [2:0]  s_axi_awsize;
    logic [1:0]  s_axi_awburst;
    logic        s_axi_awlock;
    logic [3:0]  s_axi_awcache;
    logic [2:0]  s_axi_awprot;
    logic [3:0]  s_axi_awqos;
    logic        s_axi_wvalid, s_axi_wready;
    logic [31:0] s_axi_wdata;
    logic [3:0]  s_axi_wstrb;
    logic        s_axi_wlast;
    logic        s_axi_bvalid, s_axi_bready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_arvalid, s_axi_arready;
    logic [31:0] s_axi_araddr;
    logic [7:0]  s_axi_arlen;
    logic [2:0]  s_axi_arsize;
    logic [1:0]  s_axi_arburst;
    logic        s_axi_arlock;
    logic [3:0]  s_axi_arcache;
    logic [2:0]  s_axi_arprot;
    logic [3:0]  s_axi_arqos;
    logic        s_axi_rvalid, s_axi_rready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rlast;

    axi_mem_responder #(
        .MEM_WORDS(MEM_WORDS),
        .BASE_ADDR(BASE_ADDR)
    ) dut (
        .aclk(aclk), .areset(areset),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
        .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst),
        .s_axi_awlock(s_axi_awlock), .s_axi_awcache(s_axi_awcache),
        .s_axi_awprot(s_axi_awprot), .s_axi_awqos(s_axi_awqos),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
        .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready), .s_axi_bresp(s_axi_bresp),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
        .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst),
        .s_axi_arlock(s_axi_arlock), .s_axi_arcache(s_axi_arcache),
        .s_axi_arprot(s_axi_arprot), .s_axi_arqos(s_axi_arqos),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
        logic        chk_data;
    } rbeat_t;

    rbeat_t      rq[$];
    logic [1:0]  bq[$];
    logic [31:0] model_mem [MEM_WORDS];
    logic [31:0] bdata [256];
    logic [3:0]  bstrb [256];
    logic        blast [256];

    int tests = 0;
    int fails = 0;
    int rready_pct = 100;
    int bready_pct = 100;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic fmt_bad(input logic [2:0] size, input logic [1:0] burst);
        return (size != 3'b010) || (burst != 2'b00 && burst != 2'b01);
    endfunction

    // Reference write: apply enabled bytes of in-range beats, queue the expected bresp.
    function automatic void model_write(input logic [31:0] addr, input int len,
                                        input logic [2:0] size, input logic [1:0] burst);
        logic [31:0] a, off;
        logic dec, slv;
        a = addr; dec = 1'b0; slv = fmt_bad(size, burst);
        for (int b = 0; b <= len; b++) begin
            off = a - BASE_ADDR;
            if (off >= 32'(4 * MEM_WORDS)) dec = 1'b1;
            else if (!fmt_bad(size, burst)) begin
                for (int k = 0; k < 4; k++)
                    if (bstrb[b][k]) model_mem[int'(off >> 2)][k*8 +: 8] = bdata[b][k*8 +: 8];
            end
            if (blast[b] != (b == len)) slv = 1'b1;
            if (burst == 2'b01) a = a + 32'd4;
        end
        bq.push_back(dec ? 2'b11 : (slv ? 2'b10 : 2'b00));
    endfunction

    function automatic void model_read(input logic [31:0] addr, input int len,
                                       input logic [2:0] size, input logic [1:0] burst);
        logic [31:0] a, off;
        rbeat_t e;
        a = addr;
        for (int b = 0; b <= len; b++) begin
            off = a - BASE_ADDR;
            e.last = (b == len);
            if (fmt_bad(size, burst)) begin
                e.data = '0; e.resp = 2'b10; e.chk_data = 1'b0;
            end else if (off >= 32'(4 * MEM_WORDS)) begin
                e.data = '0; e.resp = 2'b11; e.chk_data = 1'b1;
            end else begin
                e.data = model_mem[int'(off >> 2)]; e.resp = 2'b00; e.chk_data = 1'b1;
            end
            rq.push_back(e);
            if (burst == 2'b01) a = a + 32'd4;
        end
    endfunction

    function automatic void fill_beats(input int len);
        for (int b = 0; b <= len; b++) begin
            bdata[b] = $urandom;
            bstrb[b] = 4'hF;
            blast[b] = (b == len);
        end
    endfunction

    task automatic timeout_fail(input string name);
        tests++;
        fails++;
        $display("FAIL %s: handshake not seen within cycle budget, required within 200 cycles", name);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((rq.size() != 0 || bq.size() != 0) && n < 3000) begin
            @(negedge aclk);
            n++;
        end
        if (n >= 3000) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d read beats and %0d write responses outstanding, required 0",
                     rq.size(), bq.size());
            rq.delete();
            bq.delete();
        end
        @(negedge aclk);
    endtask

    task automatic send_aw(input logic [31:0] addr, input int len,
                           input logic [2:0] size, input logic [1:0] burst);
        int n;
        s_axi_awaddr = addr; s_axi_awlen = 8'(len); s_axi_awsize = size; s_axi_awburst = burst;
        s_axi_awvalid = 1'b1;
        n = 0;
        while (!s_axi_awready && n < 200) begin @(negedge aclk); n++; end
        if (n >= 200) timeout_fail("aw_handshake");
        @(negedge aclk);
        s_axi_awvalid = 1'b0;
        check("wready_after_aw", 32'(s_axi_wready), 32'd1);
    endtask

    task automatic do_write(input logic [31:0] addr, input int len, input logic [2:0] size,
                            input logic [1:0] burst, input int gap_pct);
        int n;
        model_write(addr, len, size, burst);
        send_aw(addr, len, size, burst);
        for (int b = 0; b <= len; b++) begin
            n = 0;
            while (n < 6 && $urandom_range(99) < gap_pct) begin
                s_axi_wvalid = 1'b0;
                @(negedge aclk);
                n++;
            end
            s_axi_wdata = bdata[b]; s_axi_wstrb = bstrb[b]; s_axi_wlast = blast[b];
            s_axi_wvalid = 1'b1;
            n = 0;
            while (!s_axi_wready && n < 200) begin @(negedge aclk); n++; end
            if (n >= 200) timeout_fail("w_handshake");
            @(negedge aclk);
        end
        s_axi_wvalid = 1'b0;
        s_axi_wlast = 1'b0;
        check("bvalid_after_last_w", 32'(s_axi_bvalid), 32'd1);
        drain();
    endtask

    task automatic send_ar(input logic [31:0] addr, input int len,
                           input logic [2:0] size, input logic [1:0] burst);
        int n;
        s_axi_araddr = addr; s_axi_arlen = 8'(len); s_axi_arsize = size; s_axi_arburst = burst;
        s_axi_arvalid = 1'b1;
        n = 0;
        while (!s_axi_arready && n < 200) begin @(negedge aclk); n++; end
        if (n >= 200) timeout_fail("ar_handshake");
        @(negedge aclk);
        s_axi_arvalid = 1'b0;
        check("rvalid_after_ar", 32'(s_axi_rvalid), 32'd1);
    endtask

    task automatic do_read(input logic [31:0] addr, input int len,
                           input logic [2:0] size, input logic [1:0] burst);
        model_read(addr, len, size, burst);
        send_ar(addr, len, size, burst);
        drain();
    endtask

    initial begin
        forever begin
            @(negedge aclk);
            s_axi_rready = ($urandom_range(99) < rready_pct);
            s_axi_bready = ($urandom_range(99) < bready_pct);
        end
    end

    // Monitor: pops the scoreboard on every accepted beat and checks hold-stability.
    logic        pv = 1'b0, pr = 1'b0, pl;
    logic [31:0] pd;
    logic [1:0]  pp;
    initial begin
        rbeat_t e;
        logic [1:0] eb;
        forever begin
            @(negedge aclk);
            #2;
            if (s_axi_rvalid && s_axi_rready) begin
                if (rq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL r_unexpected: beat rdata=0x%08h seen, required no beat", s_axi_rdata);
                end else begin
                    e = rq.pop_front();
                    if (e.chk_data) check("rdata", s_axi_rdata, e.data);
                    check("rresp", 32'(s_axi_rresp), 32'(e.resp));
                    check("rlast", 32'(s_axi_rlast), 32'(e.last));
                end
            end
            if (pv && !pr && s_axi_rvalid) begin
                check("rdata_hold", s_axi_rdata, pd);
                check("rresp_hold", 32'(s_axi_rresp), 32'(pp));
                check("rlast_hold", 32'(s_axi_rlast), 32'(pl));
            end
            pv = s_axi_rvalid; pr = s_axi_rready; pd = s_axi_rdata; pp = s_axi_rresp; pl = s_axi_rlast;
            if (s_axi_bvalid && s_axi_bready) begin
                if (bq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL b_unexpected: bresp=%0d seen, required no response", s_axi_bresp);
                end else begin
                    eb = bq.pop_front();
                    check("bresp", 32'(s_axi_bresp), 32'(eb));
                end
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] addr;
        int len, k;
        logic [2:0] size;
        logic [1:0] burst;

        areset = 1'b1;
        s_axi_awvalid = 1'b0; s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awsize = 3'b010;
        s_axi_awburst = 2'b01; s_axi_awlock = 1'b0; s_axi_awcache = '0; s_axi_awprot = '0;
        s_axi_awqos = '0; s_axi_wvalid = 1'b0; s_axi_wdata = '0; s_axi_wstrb = '0;
        s_axi_wlast = 1'b0; s_axi_arvalid = 1'b0; s_axi_araddr = '0; s_axi_arlen = '0;
        s_axi_arsize = 3'b010; s_axi_arburst = 2'b01; s_axi_arlock = 1'b0; s_axi_arcache = '0;
        s_axi_arprot = '0; s_axi_arqos = '0; s_axi_rready = 1'b1; s_axi_bready = 1'b1;

        repeat (3) @(negedge aclk);
        check("rst_awready", 32'(s_axi_awready), 32'd0);
        check("rst_wready",  32'(s_axi_wready),  32'd0);
        check("rst_bvalid",  32'(s_axi_bvalid),  32'd0);
        check("rst_arready", 32'(s_axi_arready), 32'd0);
        check("rst_rvalid",  32'(s_axi_rvalid),  32'd0);
        check("rst_rlast",   32'(s_axi_rlast),   32'd0);
        check("rst_bresp",   32'(s_axi_bresp),   32'd0);
        check("rst_rresp",   32'(s_axi_rresp),   32'd0);
        check("rst_rdata",   s_axi_rdata,        32'd0);
        areset = 1'b0;
        @(negedge aclk);
        check("idle_awready", 32'(s_axi_awready), 32'd1);
        check("idle_arready", 32'(s_axi_arready), 32'd1);

        // Give every word a known value.
        fill_beats(MEM_WORDS - 1);
        do_write(BASE_ADDR, MEM_WORDS - 1, 3'b010, 2'b01, 0);

        for (int b = 0; b < 4; b++) begin
            bdata[b] = 32'h1111_1111 * (b + 1); bstrb[b] = 4'hF; blast[b] = (b == 3);
        end
        do_write(32'h10, 3, 3'b010, 2'b01, 0);
        do_read(32'h10, 3, 3'b010, 2'b01);

        bdata[0] = 32'h0; bstrb[0] = 4'hF; blast[0] = 1'b1;
        do_write(32'h20, 0, 3'b010, 2'b01, 0);
        bdata[0] = 32'hAABB_CCDD; bstrb[0] = 4'b0101;
        do_write(32'h20, 0, 3'b010, 2'b01, 0);
        do_read(32'h20, 0, 3'b010, 2'b01);

        for (int b = 0; b < 3; b++) begin
            bdata[b] = 32'(b + 1); bstrb[b] = 4'hF; blast[b] = (b == 2);
        end
        do_write(32'h40, 2, 3'b010, 2'b00, 0);
        do_read(32'h40, 0, 3'b010, 2'b01);
        do_read(32'h44, 0, 3'b010, 2'b01);

        do_read(BASE_ADDR + 32'(4 * MEM_WORDS - 4), 1, 3'b010, 2'b01);
        fill_beats(1);
        do_write(BASE_ADDR + 32'(4 * MEM_WORDS - 4), 1, 3'b010, 2'b01, 0);
        do_read(BASE_ADDR, 0, 3'b010, 2'b01);
        do_read(BASE_ADDR + 32'(4 * MEM_WORDS - 4), 0, 3'b010, 2'b01);

        fill_beats(1);
        blast[0] = 1'b1; blast[1] = 1'b0;
        do_write(32'h50, 1, 3'b010, 2'b01, 0);
        do_read(32'h50, 1, 3'b010, 2'b01);
        fill_beats(1);
        do_write(32'h58, 1, 3'b001, 2'b01, 0);
        do_read(32'h58, 1, 3'b010, 2'b01);
        fill_beats(2);
        do_write(32'h60, 2, 3'b010, 2'b10, 0);
        do_read(32'h60, 2, 3'b010, 2'b10);
        do_read(32'h60, 2, 3'b010, 2'b01);

        // Same-cycle write and read of one word: the read must see the old value.
        bdata[0] = 32'h5; bstrb[0] = 4'hF; blast[0] = 1'b1;
        do_write(32'h80, 0, 3'b010, 2'b01, 0);
        bdata[0] = 32'h6;
        model_read(32'h80, 0, 3'b010, 2'b01);
        model_write(32'h80, 0, 3'b010, 2'b01);
        send_aw(32'h80, 0, 3'b010, 2'b01);
        s_axi_wdata = 32'h6; s_axi_wstrb = 4'hF; s_axi_wlast = 1'b1; s_axi_wvalid = 1'b1;
        s_axi_araddr = 32'h80; s_axi_arlen = '0; s_axi_arsize = 3'b010; s_axi_arburst = 2'b01;
        s_axi_arvalid = 1'b1;
        check("simul_readies", 32'({s_axi_wready, s_axi_arready}), 32'h3);
        @(negedge aclk);
        s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0; s_axi_arvalid = 1'b0;
        drain();
        do_read(32'h80, 0, 3'b010, 2'b01);

        // Randomized traffic with backpressure and occasional out-of-range or bad bursts.
        for (int t = 0; t < 60; t++) begin
            rready_pct = $urandom_range(30, 100);
            bready_pct = $urandom_range(30, 100);
            addr = BASE_ADDR + 32'($urandom_range(0, MEM_WORDS + 3) * 4 + $urandom_range(0, 3));
            len = $urandom_range(0, 7);
            k = $urandom_range(99);
            burst = (k < 75) ? 2'b01 : (k < 92) ? 2'b00 : (k < 96) ? 2'b10 : 2'b11;
            size = ($urandom_range(99) < 90) ? 3'b010 : 3'($urandom_range(0, 7));
            s_axi_awlock = 1'($urandom); s_axi_awcache = 4'($urandom);
            s_axi_arprot = 3'($urandom); s_axi_arqos = 4'($urandom);
            if ($urandom_range(1) == 0) begin
                fill_beats(len);
                for (int b = 0; b <= len; b++) begin
                    bstrb[b] = 4'($urandom);
                    if ($urandom_range(99) < 8) blast[b] = ~blast[b];
                end
                do_write(addr, len, size, burst, 30);
            end else begin
                do_read(addr, len, size, burst);
            end
        end

        // Reset in the middle of a stalled read burst.
        rready_pct = 0;
        @(negedge aclk);
        model_read(32'h0, 7, 3'b010, 2'b01);
        send_ar(32'h0, 7, 3'b010, 2'b01);
        @(negedge aclk);
        areset = 1'b1;
        check("arready_during_reset", 32'(s_axi_arready), 32'd0);
        @(negedge aclk);
        check("rvalid_after_reset", 32'(s_axi_rvalid), 32'd0);
        rq.delete();
        areset = 1'b0;
        @(negedge aclk);
        check("arready_after_release", 32'(s_axi_arready), 32'd1);
        rready_pct = 100;
        do_read(32'h10, 3, 3'b010, 2'b01);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
